// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared constants, types and width helpers for the TRNG post-processing path
package trng_pkg;

    localparam int BYTE_W            = 8;
    localparam int REP_LIMIT_DEFAULT = 32;

    typedef logic [BYTE_W-1:0] trng_byte_t;

    // Counter must be able to hold the value REP_LIMIT itself, hence limit+1.
    function automatic int rep_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

    localparam int REP_CNT_W   = rep_cnt_w(REP_LIMIT_DEFAULT);
    localparam int SHIFT_CNT_W = $clog2(BYTE_W);

endpackage

// File: rtl/trng_rep_count_test.sv
// rtl/trng_rep_count_test.sv - continuous repetition-count health test on the raw entropy stream
module trng_rep_count_test
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = REP_LIMIT_DEFAULT,
    parameter int CNT_W     = REP_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_bit,
    input  logic valid,
    input  logic clr,
    output logic fail_pulse
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REP_LIMIT);

    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_next;
    logic             last_bit;

    // Next run length: extend on a repeat of a live run (saturating), otherwise restart at 1.
    always_comb begin
        rep_cnt_next = rep_cnt;
        if (valid) begin
            if ((rep_cnt != '0) && (sample_bit == last_bit)) begin
                rep_cnt_next = (rep_cnt == LIMIT) ? LIMIT : rep_cnt + CNT_W'(1);
            end else begin
                rep_cnt_next = CNT_W'(1);
            end
        end
    end

    // Failure is flagged on the edge where the run length reaches the limit; a clear never masks it.
    assign fail_pulse = valid && (rep_cnt_next == LIMIT);

    // Run-length and last-bit state; the clear empties the run so counting restarts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt  <= '0;
            last_bit <= 1'b0;
        end else begin
            if (valid) begin
                last_bit <= sample_bit;
            end
            if (clr) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt_next;
            end
        end
    end

endmodule

// File: rtl/trng_vn_packer.sv
// rtl/trng_vn_packer.sv - von Neumann debiaser, health monitor and byte packer with valid/ready output
module trng_vn_packer
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = REP_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              raw_valid,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail,
    input  logic              fail_clr
);

    localparam int                      CNT_W      = rep_cnt_w(REP_LIMIT);
    localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = SHIFT_CNT_W'(BYTE_W - 1);

    // Von Neumann pair register
    logic have_first;
    logic first_bit;

    // Packing shift register; shift_full means a complete byte is parked here
    trng_byte_t             shift_reg;
    logic [SHIFT_CNT_W-1:0] shift_cnt;
    logic                   shift_full;

    logic       fail_pulse;
    logic       accept;
    logic       emit;
    logic       take_bit;
    logic       byte_done;
    logic       xfer;
    logic       out_free;
    trng_byte_t next_word;

    // The health test watches every enabled raw bit, even while the block is in failure.
    trng_rep_count_test #(
        .REP_LIMIT (REP_LIMIT),
        .CNT_W     (CNT_W)
    ) u_rep_test (
        .clk        (clk),
        .rst        (rst),
        .sample_bit (raw_bit),
        .valid      (raw_valid & en),
        .clr        (fail_clr),
        .fail_pulse (fail_pulse)
    );

    // Datapath qualifiers: pairing result, packing progress and output handshake for this cycle.
    always_comb begin
        accept    = raw_valid & en & ~health_fail;
        emit      = accept & have_first & (first_bit != raw_bit);
        take_bit  = emit & ~shift_full;
        next_word = {shift_reg[BYTE_W-2:0], first_bit};
        byte_done = take_bit & (shift_cnt == SHIFT_LAST);
        xfer      = out_valid & out_ready;
        out_free  = ~out_valid | xfer;
    end

    // Sticky health flag: set on a detected failure (which wins over a same-cycle clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            health_fail <= 1'b0;
        end else if (fail_pulse) begin
            health_fail <= 1'b1;
        end else if (fail_clr) begin
            health_fail <= 1'b0;
        end
    end

    // Pair register: hold the first bit of a pair; disabling the block drops a half-pair.
    always_ff @(posedge clk) begin
        if (rst || fail_pulse) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
        end else if (!en) begin
            have_first <= 1'b0;
        end else if (accept) begin
            if (have_first) begin
                have_first <= 1'b0;
            end else begin
                have_first <= 1'b1;
                first_bit  <= raw_bit;
            end
        end
    end

    // Packing and output register: MSB-first shift, direct load when the output is free,
    // otherwise park the byte and refill the output on the next transfer with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            shift_cnt  <= '0;
            shift_full <= 1'b0;
            out_byte   <= '0;
            out_valid  <= 1'b0;
        end else if (fail_pulse) begin
            shift_reg  <= '0;
            shift_cnt  <= '0;
            shift_full <= 1'b0;
            out_valid  <= 1'b0;
        end else if (byte_done) begin
            shift_cnt <= '0;
            if (out_free) begin
                out_byte  <= next_word;
                out_valid <= 1'b1;
            end else begin
                shift_reg  <= next_word;
                shift_full <= 1'b1;
            end
        end else begin
            if (take_bit) begin
                shift_reg <= next_word;
                shift_cnt <= shift_cnt + SHIFT_CNT_W'(1);
            end
            if (xfer) begin
                if (shift_full) begin
                    out_byte   <= shift_reg;
                    shift_full <= 1'b0;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_vn_packer.sv
// tb/tb_trng_vn_packer.sv - scoreboard bench for trng_vn_packer against a two-slot byte queue model
module tb_trng_vn_packer;

    localparam int LIMIT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       fail_clr = 1'b0;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       health_fail;

    always #5 clk = ~clk;

    trng_vn_packer #(.REP_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .fail_clr    (fail_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_hf;
    int         m_cnt;
    bit         m_last;
    bit         m_have;
    bit         m_first;
    logic [7:0] m_part;
    int         m_pcnt;
    logic [7:0] m_held[$];
    logic [7:0] exp_q[$];

    bit         exp_valid_now = 1'b0;
    bit         exp_hf_now = 1'b0;
    bit         mon_en = 1'b0;
    int         n_xfer = 0;
    int         n_valid = 0;
    logic [7:0] xfer_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming clock edge from the inputs just driven.
    task automatic model_step();
        bit rv, fail, old_hf, emit, ebit, xf;
        int newc, held_pre;
        exp_valid_now = (m_held.size() > 0);
        exp_hf_now    = m_hf;
        if (rst) begin
            m_hf = 0; m_cnt = 0; m_last = 0; m_have = 0; m_first = 0;
            m_part = 8'h00; m_pcnt = 0; m_held.delete();
            return;
        end
        rv       = raw_valid && en;
        fail     = 0;
        old_hf   = m_hf;
        held_pre = m_held.size();
        if (rv) begin
            if (m_cnt > 0 && raw_bit == m_last) newc = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
            else newc = 1;
            fail   = (newc == LIMIT);
            m_last = raw_bit;
            m_cnt  = fail_clr ? 0 : newc;
        end else if (fail_clr) begin
            m_cnt = 0;
        end
        xf = (held_pre > 0) && out_ready;
        if (xf) exp_q.push_back(m_held[0]);
        if (fail) begin
            m_hf = 1; m_held.delete(); m_pcnt = 0; m_part = 8'h00; m_have = 0;
            return;
        end
        if (fail_clr) m_hf = 0;
        emit = 0;
        ebit = 0;
        if (!en) m_have = 0;
        else if (rv && !old_hf) begin
            if (m_have) begin
                m_have = 0;
                if (m_first != raw_bit) begin emit = 1; ebit = m_first; end
            end else begin
                m_have = 1; m_first = raw_bit;
            end
        end
        if (emit && held_pre < 2) begin
            m_part = {m_part[6:0], ebit};
            m_pcnt++;
            if (m_pcnt == 8) begin m_held.push_back(m_part); m_pcnt = 0; end
        end
        if (xf) void'(m_held.pop_front());
    endtask

    // Monitor: check flags every cycle, pop and compare on each handshake the DUT presents.
    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            chk("out_valid", out_valid, exp_valid_now);
            chk("health_fail", health_fail, exp_hf_now);
            if (out_valid) n_valid++;
            if (out_valid && out_ready) begin
                n_xfer++;
                xfer_log.push_back(out_byte);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_transfer: got 0x%0h expected none", out_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_byte", out_byte, e);
                end
            end
        end
    end

    task automatic cyc(input bit rv, input bit b, input bit e, input bit rdy, input bit clr);
        @(posedge clk); #1;
        raw_valid = rv; raw_bit = b; en = e; out_ready = rdy; fail_clr = clr;
        model_step();
    endtask

    task automatic do_reset();
        repeat (2) begin
            @(posedge clk); #1;
            rst = 1; raw_valid = 0; en = 0; out_ready = 0; fail_clr = 0;
            model_step();
        end
        @(posedge clk); #1;
        rst = 0;
        model_step();
    endtask

    task automatic pair(input bit a, input bit b, input bit rdy);
        cyc(1, a, 1, rdy, 0);
        cyc(1, b, 1, rdy, 0);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rdy);
        for (int i = 7; i >= 0; i--) pair(v[i], ~v[i], rdy);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] pairs [12];
        int         base_x, base_v, stuck;
        bit         sv;
        pairs = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b01,
                  2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

        // Reset state
        do_reset();
        mon_en = 1;
        cyc(0, 0, 0, 0, 0);
        settle();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_health_fail", health_fail, 0);
        chk("reset_out_byte", out_byte, 8'h00);

        // Mixed pairs with the consumer always ready
        base_x = n_xfer; base_v = n_valid;
        foreach (pairs[i]) pair(pairs[i][1], pairs[i][0], 1);
        repeat (4) cyc(0, 0, 1, 1, 0);
        settle();
        chk("pairs_valid_cycles", n_valid - base_v, 1);
        chk("pairs_xfer_count", n_xfer - base_x, 1);
        chk("pairs_byte", xfer_log[base_x], 8'h4D);

        // Two bytes stalled, third dropped, then back-to-back drain
        do_reset();
        base_x = n_xfer;
        send_byte(8'hB2, 0);
        send_byte(8'h4D, 0);
        send_byte(8'hFF, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        settle();
        chk("stall_back_to_back", n_xfer - base_x, 2);
        repeat (4) cyc(0, 0, 1, 1, 0);
        settle();
        chk("stall_no_third", n_xfer - base_x, 2);
        chk("stall_byte0", xfer_log[base_x], 8'hB2);
        chk("stall_byte1", xfer_log[base_x + 1], 8'h4D);

        // Repetition failure flushes a partial byte; clear restarts cleanly
        do_reset();
        pair(1, 0, 1); pair(0, 1, 1); pair(1, 0, 1);
        repeat (31) cyc(1, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        settle();
        chk("rep31_no_fail", health_fail, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        settle();
        chk("rep32_fail", health_fail, 1);
        chk("rep32_out_valid", out_valid, 0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 0);
        settle();
        chk("fail_cleared", health_fail, 0);
        base_x = n_xfer;
        send_byte(8'hA5, 1);
        repeat (3) cyc(0, 0, 1, 1, 0);
        settle();
        chk("after_clr_count", n_xfer - base_x, 1);
        chk("after_clr_byte", xfer_log[base_x], 8'hA5);

        // Enable drop discards a half-pair
        do_reset();
        base_x = n_xfer;
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 0);
        send_byte(8'h3C, 1);
        repeat (3) cyc(0, 0, 1, 1, 0);
        settle();
        chk("en_drop_count", n_xfer - base_x, 1);
        chk("en_drop_byte", xfer_log[base_x], 8'h3C);

        // Failure detection wins over a coincident clear
        do_reset();
        repeat (31) cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 1);
        cyc(0, 0, 1, 1, 0);
        settle();
        chk("set_wins", health_fail, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 0);
        settle();
        chk("set_wins_cleared", health_fail, 0);

        // Randomized traffic with occasional stuck runs, stalls, disables and clears
        do_reset();
        stuck = 0;
        sv = 0;
        for (int i = 0; i < 4000; i++) begin
            bit b;
            if (stuck == 0 && $urandom_range(0, 299) == 0) begin
                stuck = $urandom_range(20, 45);
                sv = 1'($urandom_range(0, 1));
            end
            if (stuck > 0) begin b = sv; stuck--; end
            else b = 1'($urandom_range(0, 1));
            cyc(($urandom_range(0, 9) < 8), b, ($urandom_range(0, 19) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
        end
        repeat (6) cyc(0, 0, 1, 1, 0);
        settle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_vn_packer.md
Name: trng_vn_packer

Overview:
Post-processing stage that sits directly downstream of the TRNG raw entropy sampler and upstream of the tt_um_bilal_trng output pins.
- Takes one raw sampled bit per qualified cycle.
- Removes bias with a von Neumann corrector.
- Runs a continuous repetition-count health test on the raw stream.
- Packs debiased bits into bytes and presents them on a valid/ready output.

Parameters:
REP_LIMIT, 32, count of consecutive identical raw bits that declares a health failure (legal 2..255)
BYTE_W, 8, output word width in bits

Ports:
clk  in  1  system clock, sole clock domain
rst  in  1  reset; one clock; reset is synchronous and active-high
en  in  1  block enable; when low, raw input is ignored
raw_bit  in  1  raw entropy bit from the sampler
raw_valid  in  1  raw_bit is qualified this cycle
out_byte  out  BYTE_W  packed debiased byte
out_valid  out  1  out_byte holds an unconsumed byte
out_ready  in  1  consumer accepts out_byte
health_fail  out  1  sticky repetition-count failure flag
fail_clr  in  1  single-cycle pulse that clears health_fail

Behaviour:
- Reset (rst=1 at a clk edge) clears everything:
  - out_byte=0, out_valid=0, health_fail=0.
  - Pair register empty, shift count=0, shift-full flag=0, repetition count=0, last_bit=0.
- Accepted raw bit = raw_valid & en & ~health_fail.
- Von Neumann pairing:
  - The first accepted bit a is stored and have_first is set.
  - The next accepted bit b closes the pair and clears have_first.
  - If a!=b, a is emitted as one debiased bit in the same cycle. If a==b, nothing is emitted.
- Repetition test runs on every raw_valid & en bit, including while health_fail is set; the counter is not frozen.
  - If count>0 and bit==last_bit, count=min(count+1,REP_LIMIT). Otherwise count=1.
  - last_bit is updated with the bit.
  - Counter width is clog2(REP_LIMIT+1).
- health_fail sets at the edge where count becomes REP_LIMIT, so it is visible the following cycle.
  - On that same edge: the shift register, shift count and pair register are flushed, and out_valid is cleared.
  - Any byte completing on that edge is discarded.
- fail_clr clears health_fail and the repetition count.
  - If a failure is detected in the same cycle as fail_clr, set wins.
- Packing is MSB-first: shift left, new bit enters the LSB.
  - The 8th emitted bit completes the byte at edge k.
  - If the output register is free, or is transferring at edge k, the byte loads into out_byte and out_valid=1 from cycle k+1.
  - Otherwise the shift-full flag is set and the byte waits in the shift register.
- Output handshake: a transfer occurs at an edge with out_valid & out_ready.
  - A waiting full shift register is loaded on that same edge, so out_valid stays high with no bubble.
  - If nothing is waiting, out_valid=0 after the transfer edge.
  - out_byte holds its value until the next load and is never cleared by a transfer.
- While the shift-full flag is set, further debiased bits are dropped; pairing and the health test continue.
- en low:
  - have_first is cleared, discarding any half-pair.
  - The shift register and output register keep their contents, and the output still drains.
- out_valid=0 whenever health_fail=1.

Decomposition:
- Shared package trng_pkg:
  - constants BYTE_W=8 and REP_LIMIT_DEFAULT=32;
  - typedef trng_byte_t (logic [BYTE_W-1:0]);
  - a clog2-based width constant for the repetition counter.
- One sub-module, trng_rep_count_test: inputs clk, rst, bit, valid, clr; output fail_pulse.
  - Pairing and packing stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with no input -> out_valid=0, health_fail=0, out_byte=0x00.
- Pairs 01,10,00,11,01,01,10,10,01,10,10,01 with out_ready=1 -> emitted bits 0,1,0,0,1,1,0,1,1,0. The first 8 bits give out_byte=0x4D, with out_valid high for exactly 1 cycle, the cycle after the 8th bit.
- Two full bytes completed while out_ready=0, then out_ready=1 -> 0xB2 then 0x4D on consecutive transfer edges with no bubble. A third byte's bits arriving while stalled are dropped (no third valid).
- 31 consecutive raw 1s -> health_fail=0. The 32nd 1 -> health_fail=1 the next cycle, out_valid=0, partial byte flushed. A pulse on fail_clr -> health_fail=0, and the next byte builds from an empty shift register.
- en dropped between the two bits of a pair, then re-raised -> that half-pair produces no bit. Packing resumes with correct alignment: 8 subsequent unequal pairs yield exactly one byte.
- fail_clr pulsed on the same edge that the 32nd repeated bit arrives -> health_fail=1 (set wins).
